// File: rtl/sseg_pkg.sv
// Shared segment patterns and helpers for the multiplexed seven-segment driver.
// Patterns are active-high, bit order g,f,e,d,c,b,a.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_A    = 7'b1110111;
  localparam seg_t SEG_B    = 7'b1111100;
  localparam seg_t SEG_C    = 7'b0111001;
  localparam seg_t SEG_D    = 7'b1011110;
  localparam seg_t SEG_E    = 7'b1111001;
  localparam seg_t SEG_F    = 7'b1110001;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

  // Convert an active-high pattern to the pin polarity.
  function automatic seg_t seg_polarity(input seg_t s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational 4-bit code to active-high seven-segment pattern.
// Codes above 9 show a dash unless hex_mode is set.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_mode ? SEG_A : SEG_DASH;
      4'd11: seg = hex_mode ? SEG_B : SEG_DASH;
      4'd12: seg = hex_mode ? SEG_C : SEG_DASH;
      4'd13: seg = hex_mode ? SEG_D : SEG_DASH;
      4'd14: seg = hex_mode ? SEG_E : SEG_DASH;
      default: seg = hex_mode ? SEG_F : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with frame-synchronised
// loading, leading-zero blanking, decimal points and selectable polarity.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              sseg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic                  started;
  logic [DW-1:0]         pending;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic                  pending_valid;
  logic [DW-1:0]         shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic                  tick;
  logic                  last;
  logic                  frame_start;
  logic [IW-1:0]         idx_n;
  logic [DW-1:0]         shadow_n;
  logic [NUM_DIGITS-1:0] shadow_dp_n;
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
  logic [3:0]            code;
  logic                  dp_sel;
  logic                  blank_sel;
  logic [6:0]            pattern;
  logic [6:0]            seg_n;
  logic [NUM_DIGITS-1:0] onehot;

  assign tick        = (prescaler == PW'(REFRESH_DIV - 1));
  assign last        = (idx == IW'(NUM_DIGITS - 1));
  // The first tick after reset starts a frame but is not a wrap.
  assign frame_start = tick && (!started || last);
  assign idx_n       = frame_start ? '0 : idx + IW'(1);
  assign onehot      = NUM_DIGITS'(1) << idx_n;

  // Frame-boundary commit; a load on that same edge bypasses pending.
  always_comb begin
    shadow_n    = shadow;
    shadow_dp_n = shadow_dp;
    if (frame_start) begin
      if (load) begin
        shadow_n    = digits_in;
        shadow_dp_n = dp_in;
      end else if (pending_valid) begin
        shadow_n    = pending;
        shadow_dp_n = pending_dp;
      end
    end
  end

  // lz[i] is set when digit i and all higher digits are zero.
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run & (shadow_n[4*i +: 4] == 4'd0);
      lz[i] = run;
    end
  end

  always_comb begin
    code      = 4'd0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        code      = shadow_n[4*i +: 4];
        dp_sel    = shadow_dp_n[i];
        blank_sel = blank_lz && (i != 0) && lz[i];
      end
    end
  end

  sseg_decode u_decode (
    .code     (code),
    .hex_mode (HEX_MODE != 0),
    .seg      (pattern)
  );

  assign seg_n = blank_sel ? SEG_OFF : pattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler     <= '0;
      idx           <= '0;
      started       <= 1'b0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
      shadow_dp     <= '0;
      sseg_out      <= seg_polarity(SEG_OFF, SEG_INV);
      dp_out        <= SEG_INV;
      anode         <= AN_INV ? '1 : '0;
      frame_done    <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + PW'(1);
      frame_done <= tick && started && last;
      if (frame_start) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= digits_in;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end
      if (tick) begin
        started   <= 1'b1;
        idx       <= idx_n;
        shadow    <= shadow_n;
        shadow_dp <= shadow_dp_n;
        sseg_out  <= seg_polarity(seg_n, SEG_INV);
        dp_out    <= dp_sel ^ SEG_INV;
        anode     <= AN_INV ? ~onehot : onehot;
      end
    end
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit seven-segment driver. It is the successor to the team's single-digit BCD decoder.
- Takes a packed vector of 4-bit digit codes and scans one digit per refresh tick across NUM_DIGITS common-anode/cathode positions.
- Adds leading-zero blanking, per-digit decimal points, hex/BCD modes, selectable output polarity, and tear-free frame-synchronised loading.
- Sits between the reaction-timer counter/datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (1..8); digit 0 is least significant.
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- HEX_MODE, 0, 1 decodes codes 10..15 as A,b,C,d,E,F; 0 shows dash for codes >9.
- SEG_ACTIVE_LOW, 1, 1 inverts sseg_out and dp_out (lit = 0).
- AN_ACTIVE_LOW, 1, 1 inverts anode (selected = 0).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- digits_in  input  4*NUM_DIGITS  packed digit codes; digit i is [4i+3:4i].
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- load  input  1  capture digits_in/dp_in into the pending register this cycle.
- blank_lz  input  1  enable leading-zero blanking.
- sseg_out  output  7  segments, bit order g,f,e,d,c,b,a (bit6=g, bit0=a).
- dp_out  output  1  decimal point for the active digit.
- anode  output  NUM_DIGITS  one-hot digit select.
- frame_done  output  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (async, rst=1) state:
  - prescaler=0, digit index=0.
  - pending and shadow registers=0, pending_valid=0.
  - sseg_out and dp_out all unlit: SEG_ACTIVE_LOW=1 gives 7'b1111111 and dp_out=1.
  - anode all deselected, frame_done=0.
- First slot after reset: the first tick after reset release selects digit 0. Anodes stay off until that tick.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 on the cycle it equals REFRESH_DIV-1.
- Digit index: on each tick, index advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Registered outputs: anode, sseg_out and dp_out update on the same edge as the index and reflect the new index. Latency from tick to pins is 0 cycles after that edge.
- frame_done:
  - Asserted for exactly one cycle, on the edge where index wraps to 0.
  - Not asserted on the first tick after reset.
- load:
  - load=1 captures into pending and sets pending_valid.
  - A second load before commit overwrites pending; last value wins.
- Commit to shadow:
  - pending is copied to shadow, and pending_valid cleared, on the index-wrap edge.
  - The newly committed shadow drives digit 0 of that same frame.
  - Result: a frame never shows mixed old and new digits.
- load coincident with the wrap edge: the incoming digits_in/dp_in commit directly to shadow and pending_valid stays 0.
- Decode, active-high internal encoding (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - HEX_MODE=1: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - HEX_MODE=0: codes 10..15 show dash=1000000.
- Leading-zero blanking, when blank_lz=1:
  - Digit i is blanked (segments unlit) when shadow digit i and every higher digit are all zero.
  - Digit 0 is never blanked.
  - dp still lights on a blanked digit if its dp bit is set.
- Polarity: applied last, on the registered outputs only.
- blank_lz: sampled live, not shadowed; a change takes effect at the next tick.

Decomposition:
- Shared package sseg_pkg holds:
  - segment pattern constants SEG_0..SEG_F, SEG_DASH, SEG_OFF;
  - a 7-bit segment typedef;
  - a function for the polarity invert.
- Sub-module sseg_decode: combinational, 4-bit code plus hex_mode in, 7-bit active-high pattern out. It replaces the single-digit decoder for all new designs.
- Top level holds the prescaler, index, pending/shadow registers, blanking logic and output registers.

Test Plan:
- Basic scan (NUM_DIGITS=4, REFRESH_DIV=4, active-low): reset, then load 16'h1234 -> after first wrap, the slots show:
  - digit0: anode=1110, sseg=0011001 (4);
  - digit1: anode=1101, sseg=0110000 (3);
  - digit2: anode=1011, sseg=0100100 (2);
  - digit3: anode=0111, sseg=1111001 (1).
  - frame_done pulses every 16 cycles.
- Leading-zero blanking: load 16'h0070 with blank_lz=1 -> digit3 and digit2 sseg=1111111, digit1 shows 7 (1111000), digit0 shows 0 (1000000). Load 16'h0000 -> only digit0 lit, showing 0.
- Tear-free load: load 16'h5678 mid-frame while 16'h1234 is displayed -> rest of the frame still shows 1234. The next frame shows 5678 starting at digit0. A load at the exact wrap edge commits the same cycle.
- Mode and dp: with HEX_MODE=0, code 4'hB shows dash (active-low 0111111). With HEX_MODE=1, code 4'hB shows b (0000011). dp_in=4'b0100 -> dp_out=0 only in the digit2 slot.
- Async reset mid-scan: assert rst between clk edges during the digit2 slot -> immediately anode=1111, sseg=1111111, dp_out=1, frame_done=0, shadow cleared. After release, the first tick selects digit0 again.
